top_level: RTL and testbench
============================

TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 Parameter: DM_DEPTH, default 256, number of 8-bit data-memory words.
REQ-002 Parameter: PC_W, default 8, program-counter width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: done  output  1  high while the processor is halted on a HALT instruction.
REQ-006 Data memory SHALL be a submodule instance named dm1 whose storage is an array named core, DM_DEPTH x 8 bits, directly readable and writable by hierarchical reference.

Function
REQ-007 Core SHALL be a single-cycle processor:
- PC (PC_W bits)
- hardwired 9-bit instruction ROM indexed by PC
- 8 x 8-bit register file r0..r7
- ALU
- dm1
REQ-008 Instruction format SHALL be [8:6] opcode, [5:3] rd, [2:0] rs.
REQ-009 Opcodes SHALL be:
- 000 LDR: rd = core[r[rs]]
- 001 STR: core[r[rs]] = r[rd]
- 010 ADD: rd = rd + rs
- 011 AND: rd = rd & rs
- 100 XOR: rd = rd ^ rs
- 101 LDI: rd = zero-extended 3-bit rs field
- 110 NOP
- 111 HALT
REQ-010 ADD SHALL be 8-bit modulo, carry discarded; no flags exist.
REQ-011 dm1 read SHALL be combinational; dm1 write SHALL occur on the rising clk edge only during STR.
REQ-012 Register-file writes (LDR, ADD, AND, XOR, LDI) SHALL occur on the rising clk edge; r0 SHALL be an ordinary register.
REQ-013 PC SHALL increment by 1 each cycle, except while the instruction at PC is HALT, when PC holds.
REQ-014 done SHALL equal 1 exactly when the current instruction is HALT and reset is low; once high it SHALL stay high until reset.
REQ-015 ROM addresses 0-14 SHALL contain, in order:
- LDI r1,0; LDR r2,[r1]; LDI r1,1; LDR r3,[r1]; ADD r2,r3; LDI r1,2; STR r2,[r1]
- LDI r1,3; LDR r2,[r1]; LDI r1,4; LDR r3,[r1]; AND r2,r3; LDI r1,5; STR r2,[r1]
- HALT
REQ-016 All other ROM addresses SHALL hold HALT.
REQ-017 The program SHALL leave core[2] = core[0] + core[1] (mod 256) and core[5] = core[3] & core[4].
REQ-018 No other core location SHALL be written.
REQ-019 Addresses beyond DM_DEPTH-1 SHALL wrap modulo DM_DEPTH.

Reset
REQ-020 Reset SHALL set PC = 0, all registers = 0, done = 0 on the next rising edge.
REQ-021 Reset SHALL NOT modify dm1.core; values preloaded before or during reset SHALL be preserved.
REQ-022 Reset asserted mid-program SHALL abort the current instruction, including any pending STR write. After release, the program SHALL restart from address 0 using current memory contents.
REQ-023 With reset held high, no dm1 or register writes SHALL occur and done SHALL be 0.
REQ-024 After reset release, done SHALL rise within 15 clock cycles.

Verification
REQ-025 Preload core[0]=F0, core[1]=CC, core[3]=C3, core[4]=55; pulse reset 1 cycle; wait done -> core[2]=BC, core[5]=41; core[0,1,3,4] unchanged.
REQ-026 Preload core[0]=FF, core[1]=01 -> core[2]=00 (carry dropped).
REQ-027 Preload core[3]=00, core[4]=FF -> core[5]=00; core[6..255] unchanged.
REQ-028 Assert reset at cycle 5 of a run, release, rerun -> identical results to REQ-025; done low during reset and high 15 cycles after release.
REQ-029 After done, run 20 more cycles -> done stays 1, PC constant, memory unchanged.
REQ-030 Hold reset 10 cycles with preloaded memory -> no memory change, done=0 throughout.

Source files
------------

// File: rtl/top_level_if.sv
// rtl/top_level_if.sv - data-memory bus between the processor core and dm1
interface top_level_if #(
  parameter int AW = 8
) ();
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          we;
  logic [7:0]    rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/top_level.sv
// rtl/top_level.sv - single-cycle 8-bit processor with hardwired ROM and data memory dm1

// Data memory: combinational read, write on the rising edge when we is set.
// The contents are never reset so preloaded values survive a reset pulse.
module top_level_dm #(
  parameter int DM_DEPTH = 256,
  parameter int AW       = 8
) (
  input logic        clk,
  top_level_if.slave bus
);
  logic [7:0] core [DM_DEPTH];

  // Store port, only active while the core is executing STR
  always_ff @(posedge clk) begin
    if (bus.we) core[bus.addr] <= bus.wdata;
  end

  assign bus.rdata = core[bus.addr];
endmodule

module top_level #(
  parameter int DM_DEPTH = 256,
  parameter int PC_W     = 8
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  localparam int AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  localparam logic [2:0] OP_LDR  = 3'b000;
  localparam logic [2:0] OP_STR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Program: core[2] = core[0] + core[1]; core[5] = core[3] & core[4]; halt.
  // Unused addresses hold HALT so a runaway PC parks itself.
  function automatic logic [8:0] rom(input logic [PC_W-1:0] a);
    case (32'(a))
      0:       rom = {OP_LDI, 3'd1, 3'd0};
      1:       rom = {OP_LDR, 3'd2, 3'd1};
      2:       rom = {OP_LDI, 3'd1, 3'd1};
      3:       rom = {OP_LDR, 3'd3, 3'd1};
      4:       rom = {OP_ADD, 3'd2, 3'd3};
      5:       rom = {OP_LDI, 3'd1, 3'd2};
      6:       rom = {OP_STR, 3'd2, 3'd1};
      7:       rom = {OP_LDI, 3'd1, 3'd3};
      8:       rom = {OP_LDR, 3'd2, 3'd1};
      9:       rom = {OP_LDI, 3'd1, 3'd4};
      10:      rom = {OP_LDR, 3'd3, 3'd1};
      11:      rom = {OP_AND, 3'd2, 3'd3};
      12:      rom = {OP_LDI, 3'd1, 3'd5};
      13:      rom = {OP_STR, 3'd2, 3'd1};
      default: rom = {OP_HALT, 3'd0, 3'd0};
    endcase
  endfunction

  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      rf_q [8];
  logic [8:0]      instr;
  logic [2:0]      opcode, rd, rs;
  logic [7:0]      rd_val, rs_val;
  logic            rf_we;
  logic [7:0]      rf_wdata;
  logic            mem_we;

  top_level_if #(.AW(AW)) dm_bus ();

  top_level_dm #(.DM_DEPTH(DM_DEPTH), .AW(AW)) dm1 (
    .clk (clk),
    .bus (dm_bus.slave)
  );

  assign instr  = rom(pc_q);
  assign opcode = instr[8:6];
  assign rd     = instr[5:3];
  assign rs     = instr[2:0];
  assign rd_val = rf_q[rd];
  assign rs_val = rf_q[rs];

  // Address wraps modulo the memory depth; writes are suppressed during reset
  // so an STR in flight when reset arrives is dropped.
  assign dm_bus.addr  = AW'(32'(rs_val) % DM_DEPTH);
  assign dm_bus.wdata = rd_val;
  assign dm_bus.we    = mem_we && !reset;

  assign done = (opcode == OP_HALT) && !reset;

  // Decode, ALU and next-PC selection for the instruction at pc_q
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = 8'h00;
    mem_we   = 1'b0;
    pc_d     = pc_q + 1'b1;
    case (opcode)
      OP_LDR:  begin rf_we = 1'b1; rf_wdata = dm_bus.rdata;        end
      OP_STR:  begin mem_we = 1'b1;                                end
      OP_ADD:  begin rf_we = 1'b1; rf_wdata = rd_val + rs_val;     end
      OP_AND:  begin rf_we = 1'b1; rf_wdata = rd_val & rs_val;     end
      OP_XOR:  begin rf_we = 1'b1; rf_wdata = rd_val ^ rs_val;     end
      OP_LDI:  begin rf_we = 1'b1; rf_wdata = {5'b00000, rs};      end
      OP_NOP:  begin                                               end
      default: begin pc_d = pc_q;                                  end
    endcase
  end

  // PC and register file update; reset clears both but leaves memory alone
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 8'h00;
    end else begin
      pc_q <= pc_d;
      if (rf_we) rf_q[rd] <= rf_wdata;
    end
  end
endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - directed self-checking bench for top_level
module tb_top_level;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] model [256];

  top_level #(.DM_DEPTH(256), .PC_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    dut.dm1.core[a] = v;
    model[a] = v;
  endtask

  task automatic mem_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.dm1.core[i] !== model[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  // HALT sits at address 14, so done appears 14 edges after release.
  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'd14);
  endtask

  initial begin
    reset = 1'b1;
    cyc(1);
    for (int i = 0; i < 256; i++) poke(i, 8'(i) ^ 8'hA5);
    poke(0, 8'hF0); poke(1, 8'hCC); poke(3, 8'hC3); poke(4, 8'h55);
    cyc(1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pc", 32'(dut.pc_q), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("reset_r%0d", i), 32'(dut.rf_q[i]), 32'd0);

    // Reset held for 10 cycles: no writes, done low
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hold_done", 32'(done), 32'd0);
    end
    mem_check("hold_mem");

    // Run 1: F0+CC = BC, C3&55 = 41
    reset = 1'b0;
    wait_done("run1");
    model[2] = 8'hBC;
    model[5] = 8'h41;
    chk("run1_core2", 32'(dut.dm1.core[2]), 32'h BC);
    chk("run1_core5", 32'(dut.dm1.core[5]), 32'h41);
    mem_check("run1_mem");
    chk("run1_r1", 32'(dut.rf_q[1]), 32'h05);
    chk("run1_r2", 32'(dut.rf_q[2]), 32'h41);
    chk("run1_r3", 32'(dut.rf_q[3]), 32'h55);

    // Stay halted for 20 more cycles
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_pc", 32'(dut.pc_q), 32'd14);
    end
    mem_check("halt_mem");

    // Run 2: FF+01 carry dropped, 00&FF
    reset = 1'b1;
    cyc(1);
    chk("run2_rst_done", 32'(done), 32'd0);
    poke(0, 8'hFF); poke(1, 8'h01); poke(3, 8'h00); poke(4, 8'hFF);
    reset = 1'b0;
    wait_done("run2");
    model[2] = 8'h00;
    model[5] = 8'h00;
    chk("run2_core2", 32'(dut.dm1.core[2]), 32'h00);
    chk("run2_core5", 32'(dut.dm1.core[5]), 32'h00);
    mem_check("run2_mem");

    // Run 3: aborted mid-program, then rerun
    reset = 1'b1;
    cyc(1);
    poke(0, 8'hF0); poke(1, 8'hCC); poke(3, 8'hC3); poke(4, 8'h55);
    poke(2, 8'h11); poke(5, 8'h22);
    reset = 1'b0;
    cyc(5);
    chk("abort5_pc", 32'(dut.pc_q), 32'd5);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("abort5_done", 32'(done), 32'd0);
    end
    chk("abort5_pc_rst", 32'(dut.pc_q), 32'd0);
    chk("abort5_r2_rst", 32'(dut.rf_q[2]), 32'd0);
    mem_check("abort5_mem");

    // Reset lands while STR r2,[r1] is the current instruction
    reset = 1'b0;
    cyc(6);
    chk("abort6_pc", 32'(dut.pc_q), 32'd6);
    chk("abort6_r2", 32'(dut.rf_q[2]), 32'h BC);
    reset = 1'b1;
    cyc(1);
    chk("abort6_done", 32'(done), 32'd0);
    chk("abort6_core2", 32'(dut.dm1.core[2]), 32'h11);
    mem_check("abort6_mem");

    reset = 1'b0;
    wait_done("run3");
    model[2] = 8'hBC;
    model[5] = 8'h41;
    chk("run3_core2", 32'(dut.dm1.core[2]), 32'h BC);
    chk("run3_core5", 32'(dut.dm1.core[5]), 32'h41);
    mem_check("run3_mem");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
